// File: rtl/apb_slave_mem_pkg.sv
// Shared types and constants for the APB completer memory and its bus interface.
package apb_slave_mem_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 8;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_e;

  typedef enum logic {
    OKAY   = 1'b0,
    SLVERR = 1'b1
  } apb_resp_e;

  // Transfer captured in the setup phase; the access phase works only from this copy.
  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] data;
    logic                  wr;
  } apb_req_t;

  function automatic logic addr_is_err(input logic [APB_ADDR_W-1:0] addr,
                                       input int unsigned depth);
    return (32'(addr) >= depth);
  endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB completer-side bus bundle with requester and completer views.
interface apb_slave_mem_if
  import apb_slave_mem_pkg::*;
();

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_ADDR_W-1:0] paddr;
  logic [APB_DATA_W-1:0] pwdata;
  logic [APB_DATA_W-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_slave_mem_ram.sv
// DEPTH x DATA_W flop array: async clear, one write port, one combinational read port.
module apb_slave_mem_ram #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_c = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer memory: setup/access decode, fixed wait states, range-checked read/write.
module apb_slave_mem
  import apb_slave_mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  apb_slave_mem_if.slave apb_s
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_slv_state_e        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  apb_req_t              req_q, req_d;
  logic                  err_q, err_d;
  logic                  ram_we;
  logic [APB_DATA_W-1:0] ram_rdata;

  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [APB_DATA_W-1:0] prdata_q, prdata_d;

  assign err_q = addr_is_err(req_q.addr, DEPTH);
  assign err_d = addr_is_err(req_d.addr, DEPTH);

  // State register, wait counter, latched request and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Next-state: setup capture, wait countdown, abort on PSEL drop, commit on completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    ram_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (apb_s.psel && !apb_s.penable) begin
          state_d    = ACCESS;
          cnt_d      = CNT_W'(WAIT_STATES);
          req_d.addr = apb_s.paddr;
          req_d.data = apb_s.pwdata;
          req_d.wr   = apb_s.pwrite;
        end
      end
      ACCESS: begin
        if (!apb_s.psel) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
          ram_we  = req_q.wr && !err_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed one edge early from next-state so they leave straight from flops.
  always_comb begin
    pready_d  = (state_d == ACCESS) && (cnt_d == '0);
    pslverr_d = pready_d && err_d;
    prdata_d  = '0;
    if (pready_d && !req_d.wr && !err_d) begin
      prdata_d = ram_rdata;
    end
  end

  apb_slave_mem_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (APB_DATA_W),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ram_we),
    .waddr_i (req_q.addr[IDX_W-1:0]),
    .wdata_i (req_q.data),
    .raddr_i (req_d.addr[IDX_W-1:0]),
    .rdata_c (ram_rdata)
  );

  assign apb_s.pready  = pready_q;
  assign apb_s.pslverr = pslverr_q;
  assign apb_s.prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: a 2-wait-state instance and a zero-wait instance.
module tb_apb_slave_mem;

  typedef struct {
    bit         sel;
    logic [7:0] rdata;
    bit         err;
    int         waits;
    int         gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [7:0] paddr = '0;
  logic [7:0] pwdata = '0;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  apb_slave_mem_if ia ();
  apb_slave_mem_if ib ();

  assign ia.psel    = psel & ~sel;
  assign ia.penable = penable;
  assign ia.pwrite  = pwrite;
  assign ia.paddr   = paddr;
  assign ia.pwdata  = pwdata;
  assign ib.psel    = psel & sel;
  assign ib.penable = penable;
  assign ib.pwrite  = pwrite;
  assign ib.paddr   = paddr;
  assign ib.pwdata  = pwdata;

  apb_slave_mem #(.DEPTH(64), .WAIT_STATES(2)) u_a (.clk(clk), .rst_n(rst_n), .apb_s(ia));
  apb_slave_mem #(.DEPTH(64), .WAIT_STATES(0)) u_b (.clk(clk), .rst_n(rst_n), .apb_s(ib));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per PREADY, and requires quiet outputs otherwise.
  int cyc = 0;
  int last_done = 0;
  int waits = 0;
  always @(negedge clk) begin
    exp_t e;
    logic       rdy;
    logic [7:0] rd;
    logic       er;
    cyc++;
    if (!rst_n) begin
      waits = 0;
    end else begin
      rdy = ia.pready | ib.pready;
      if (rdy) begin
        rd = ib.pready ? ib.prdata : ia.prdata;
        er = ib.pready ? ib.pslverr : ia.pslverr;
        if (q.size() == 0) begin
          chk("unexpected_pready", 1, 0);
        end else begin
          e = q.pop_front();
          chk("prdata", int'(rd), int'(e.rdata));
          chk("pslverr", int'(er), int'(e.err));
          chk("wait_states", waits, e.waits);
          chk("responding_dut", int'(ib.pready), int'(e.sel));
          if (e.gap != 0) chk("completion_gap", cyc - last_done, e.gap);
        end
        last_done = cyc;
        waits = 0;
      end else begin
        chk("idle_outputs_zero",
            int'({ia.prdata | ib.prdata, ia.pslverr | ib.pslverr}), 0);
        if (psel && penable) waits++;
        else waits = 0;
      end
    end
  end

  // Full transfer; address/data are scrambled after setup to prove the latch is used.
  task automatic xfer(input bit s, input bit wr, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] erd, input bit eerr, input int gap, input bit last);
    exp_t e;
    int   n;
    bit   done;
    e.sel = s; e.rdata = erd; e.err = eerr; e.waits = s ? 0 : 2; e.gap = gap;
    q.push_back(e);
    sel = s; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1; paddr = ~a; pwdata = ~d;
    n = 0; done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      done = s ? ib.pready : ia.pready;
      @(posedge clk); #1;
      n++;
    end
    chk("transfer_completed", int'(done), 1);
    if (last) begin
      psel = 1'b0; penable = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pready", int'(ia.pready), 0);
    chk("reset_pslverr", int'(ia.pslverr), 0);
    chk("reset_prdata", int'(ia.prdata), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset asserted while a read is presenting data.
    xfer(0, 1, 8'h05, 8'h99, 8'h00, 0, 0, 1);
    q.push_back('{sel: 0, rdata: 8'h99, err: 0, waits: 2, gap: 0});
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h05;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ia.pready && n < 10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pready", int'(ia.pready), 0);
    chk("async_rst_pslverr", int'(ia.pslverr), 0);
    chk("async_rst_prdata", int'(ia.prdata), 0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset during the wait phase of a write: the write must never land.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h06; pwdata = 8'h55;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    #2 rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    xfer(0, 0, 8'h05, 8'h00, 8'h00, 0, 0, 1);
    xfer(0, 0, 8'h06, 8'h00, 8'h00, 0, 0, 1);

    // Basic write then read.
    xfer(0, 1, 8'h05, 8'hA5, 8'h00, 0, 0, 1);
    xfer(0, 0, 8'h05, 8'h00, 8'hA5, 0, 0, 1);

    // Out-of-range address at DEPTH, and memory left untouched.
    xfer(0, 1, 8'h40, 8'h3C, 8'h00, 1, 0, 1);
    xfer(0, 0, 8'h40, 8'h00, 8'h00, 1, 0, 1);
    xfer(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1);
    xfer(0, 0, 8'hFF, 8'h00, 8'h00, 1, 0, 1);

    // Back-to-back with no idle cycle between transfers.
    xfer(0, 1, 8'h01, 8'h11, 8'h00, 0, 0, 0);
    xfer(0, 1, 8'h02, 8'h22, 8'h00, 0, 4, 0);
    xfer(0, 0, 8'h01, 8'h00, 8'h11, 0, 4, 0);
    xfer(0, 0, 8'h02, 8'h00, 8'h22, 0, 4, 1);

    // Abort after one access cycle of a write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h07; pwdata = 8'hFF;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    xfer(0, 0, 8'h07, 8'h00, 8'h00, 0, 0, 1);

    // PENABLE without a setup phase is ignored.
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h08; pwdata = 8'h77;
    repeat (5) @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    xfer(0, 0, 8'h08, 8'h00, 8'h00, 0, 0, 1);

    // Zero-wait instance: top word round-trip, back-to-back every 2 cycles.
    xfer(1, 1, 8'h3F, 8'h5A, 8'h00, 0, 0, 0);
    xfer(1, 0, 8'h3F, 8'h00, 8'h5A, 0, 2, 1);
    xfer(1, 0, 8'h40, 8'h00, 8'h00, 1, 0, 1);
    xfer(0, 0, 8'h3F, 8'h00, 8'h00, 0, 0, 1);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
